// File: rtl/pvr_pkg.sv
// Shared definitions for the region-array writer: control word layout, list indices,
// FSM encoding and OPB sizing helpers.
package pvr_pkg;

  localparam int RA_LAST      = 31;
  localparam int RA_ZCLEAR    = 30;
  localparam int RA_FLUSH     = 28;
  localparam int RA_TILEY_LSB = 8;
  localparam int RA_TILEX_LSB = 2;

  localparam logic [31:0] RA_UNUSED = 32'h8000_0000;

  localparam int NUM_LISTS  = 5;
  localparam int FMT_V2_BIT = 21;

  localparam logic [2:0] L_O  = 3'd0;
  localparam logic [2:0] L_OM = 3'd1;
  localparam logic [2:0] L_T  = 3'd2;
  localparam logic [2:0] L_TM = 3'd3;
  localparam logic [2:0] L_PT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WR_CTRL = 3'd2,
    ST_WR_LIST = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } ra_state_t;

  // Per-tile OPB footprint of one list: 16 << code bytes, nothing for code 0.
  function automatic logic [23:0] opb_bytes(input logic [1:0] code);
    logic [23:0] bytes;
    case (code)
      2'd1:    bytes = 24'd32;
      2'd2:    bytes = 24'd64;
      2'd3:    bytes = 24'd128;
      default: bytes = 24'd0;
    endcase
    return bytes;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic       last,
                                            input logic       no_zclear,
                                            input logic       no_flush,
                                            input logic [5:0] tile_y,
                                            input logic [5:0] tile_x);
    logic [31:0] word;
    word                             = 32'h0000_0000;
    word[RA_LAST]                    = last;
    word[RA_ZCLEAR]                  = no_zclear;
    word[RA_FLUSH]                   = no_flush;
    word[RA_TILEY_LSB +: 6]          = tile_y;
    word[RA_TILEX_LSB +: 6]          = tile_x;
    return word;
  endfunction

endpackage

// File: rtl/ra_ol_alloc.sv
// Object-list pointer allocator: lays out list bases during setup, then steps each
// used pointer by its per-tile OPB size as the builder moves to the next tile.
module ra_ol_alloc
  import pvr_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic [23:0]                     ol_base,
  input  logic [31:0]                     alloc_ctrl,
  input  logic                            fmt_v2,
  input  logic [12:0]                     ntiles,
  input  logic                            setup_en,
  input  logic [2:0]                      setup_idx,
  input  logic                            advance,
  output logic [NUM_LISTS-1:0][23:0]      ptr,
  output logic [NUM_LISTS-1:0]            used
);

  logic [NUM_LISTS-1:0][1:0] codes;
  logic                      fmt;
  logic [12:0]               ntiles_q;
  logic [23:0]               acc;
  logic [23:0]               span;
  logic [2:0]                shift;

  // Punch-through only exists in the 6-word entry format.
  always_comb begin
    used = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      if (i == int'(L_PT)) begin
        used[i] = (codes[i] != 2'd0) && fmt;
      end else begin
        used[i] = (codes[i] != 2'd0);
      end
    end
  end

  always_comb begin
    shift = {1'b0, codes[setup_idx]} + 3'd4;
    if (used[setup_idx]) begin
      span = {11'd0, ntiles_q} << shift;
    end else begin
      span = 24'd0;
    end
  end

  // Config latch, setup-time base accumulation and per-tile pointer stepping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      codes    <= '0;
      fmt      <= 1'b0;
      ntiles_q <= 13'd0;
      acc      <= 24'd0;
      ptr      <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        codes[i] <= alloc_ctrl[4*i +: 2];
      end
      fmt      <= fmt_v2;
      ntiles_q <= ntiles;
      acc      <= ol_base;
      ptr      <= '0;
    end else if (setup_en) begin
      ptr[setup_idx] <= acc;
      acc            <= acc + span;
    end else if (advance) begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        if (used[i]) begin
          ptr[i] <= ptr[i] + opb_bytes(codes[i]);
        end
      end
    end
  end

endmodule

// File: rtl/ra_builder.sv
// Region Array builder: walks the tile grid once per trigger and writes one control word
// plus one object-list pointer per list for every tile through a single-outstanding VRAM port.
module ra_builder
  import pvr_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ra_build_trig,
  input  logic [31:0] REGION_BASE,
  input  logic [31:0] OL_BASE,
  input  logic [31:0] FPU_PARAM_CFG,
  input  logic [31:0] TA_ALLOC_CTRL,
  input  logic [5:0]  tile_x_max,
  input  logic [5:0]  tile_y_max,
  input  logic        no_zclear,
  input  logic        no_flush,
  output logic        vram_wr,
  output logic [23:0] vram_addr,
  output logic [31:0] vram_dout,
  input  logic        vram_ack,
  output logic        busy,
  output logic        done
);

  ra_state_t state, next_state;

  logic [2:0]  setup_cnt, list_idx, last_idx, next_list;
  logic [5:0]  tile_x, tile_y, x_max, y_max;
  logic [5:0]  nx, ny, up_x, up_y;
  logic        fmt_v2, nz, nf;
  logic        start, acked, is_last, up_last;
  logic [12:0] ntiles_in;

  logic [NUM_LISTS-1:0][23:0] alloc_ptr;
  logic [NUM_LISTS-1:0]       alloc_used;

  logic        wr_next, busy_next, done_next;
  logic [23:0] addr_next;
  logic [31:0] dout_next, list_word;

  assign start     = (state == ST_IDLE) && ra_build_trig;
  assign acked     = vram_wr && vram_ack;
  assign is_last   = (tile_x == x_max) && (tile_y == y_max);
  assign last_idx  = fmt_v2 ? L_PT : L_TM;
  assign ntiles_in = ({7'd0, tile_x_max} + 13'd1) * ({7'd0, tile_y_max} + 13'd1);

  ra_ol_alloc u_alloc (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (start),
    .ol_base    (OL_BASE[23:0]),
    .alloc_ctrl (TA_ALLOC_CTRL),
    .fmt_v2     (FPU_PARAM_CFG[FMT_V2_BIT]),
    .ntiles     (ntiles_in),
    .setup_en   (state == ST_SETUP),
    .setup_idx  (setup_cnt),
    .advance    ((state == ST_NEXT) && !is_last),
    .ptr        (alloc_ptr),
    .used       (alloc_used)
  );

  // Upcoming tile coordinates and the next word to present after an ack.
  always_comb begin
    nx = tile_x + 6'd1;
    ny = tile_y;
    if (tile_x == x_max) begin
      nx = 6'd0;
      ny = tile_y + 6'd1;
    end else begin
      nx = tile_x + 6'd1;
      ny = tile_y;
    end
    if (state == ST_SETUP) begin
      up_x = 6'd0;
      up_y = 6'd0;
    end else begin
      up_x = nx;
      up_y = ny;
    end
    up_last   = (up_x == x_max) && (up_y == y_max);
    next_list = (state == ST_WR_CTRL) ? L_O : list_idx + 3'd1;
    list_word = alloc_used[next_list] ? {8'h00, alloc_ptr[next_list]} : RA_UNUSED;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    next_state = ra_build_trig ? ST_SETUP : ST_IDLE;
      ST_SETUP:   next_state = (setup_cnt == 3'd4) ? ST_WR_CTRL : ST_SETUP;
      ST_WR_CTRL: next_state = acked ? ST_WR_LIST : ST_WR_CTRL;
      ST_WR_LIST: next_state = (acked && (list_idx == last_idx)) ? ST_NEXT : ST_WR_LIST;
      ST_NEXT:    next_state = is_last ? ST_DONE : ST_WR_CTRL;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode: values the output registers take on the coming edge.
  always_comb begin
    wr_next   = (next_state == ST_WR_CTRL) || (next_state == ST_WR_LIST);
    busy_next = (next_state != ST_IDLE) && (next_state != ST_DONE);
    done_next = (next_state == ST_DONE);
    if (start) begin
      addr_next = REGION_BASE[23:0];
    end else if (acked) begin
      addr_next = vram_addr + 24'd4;
    end else begin
      addr_next = vram_addr;
    end
    dout_next = vram_dout;
    case (state)
      ST_SETUP: begin
        if (setup_cnt == 3'd4) dout_next = ctrl_word(up_last, nz, nf, up_y, up_x);
        else                   dout_next = vram_dout;
      end
      ST_WR_CTRL: begin
        if (acked) dout_next = list_word;
        else       dout_next = vram_dout;
      end
      ST_WR_LIST: begin
        if (acked && (list_idx != last_idx)) dout_next = list_word;
        else                                 dout_next = vram_dout;
      end
      ST_NEXT: begin
        if (!is_last) dout_next = ctrl_word(up_last, nz, nf, up_y, up_x);
        else          dout_next = vram_dout;
      end
      default: dout_next = vram_dout;
    endcase
  end

  // Registered VRAM port and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vram_wr   <= 1'b0;
      vram_addr <= 24'd0;
      vram_dout <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      vram_wr   <= wr_next;
      vram_addr <= addr_next;
      vram_dout <= dout_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Build context: config sampled at trigger, setup/list counters and tile position.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_max     <= 6'd0;
      y_max     <= 6'd0;
      fmt_v2    <= 1'b0;
      nz        <= 1'b0;
      nf        <= 1'b0;
      tile_x    <= 6'd0;
      tile_y    <= 6'd0;
      setup_cnt <= 3'd0;
      list_idx  <= 3'd0;
    end else if (start) begin
      x_max     <= tile_x_max;
      y_max     <= tile_y_max;
      fmt_v2    <= FPU_PARAM_CFG[FMT_V2_BIT];
      nz        <= no_zclear;
      nf        <= no_flush;
      tile_x    <= 6'd0;
      tile_y    <= 6'd0;
      setup_cnt <= 3'd0;
      list_idx  <= 3'd0;
    end else if (state == ST_SETUP) begin
      setup_cnt <= setup_cnt + 3'd1;
    end else if ((state == ST_WR_CTRL) && acked) begin
      list_idx <= 3'd0;
    end else if ((state == ST_WR_LIST) && acked) begin
      list_idx <= list_idx + 3'd1;
    end else if ((state == ST_NEXT) && !is_last) begin
      tile_x <= nx;
      tile_y <= ny;
    end
  end

endmodule
